// File: rtl/wir_sequencer.sv
// wir_sequencer: IEEE 1500 wrapper instruction register plus WBR sequencing.
// The serial WIR is shifted/updated over WSC. The active instruction is decoded
// into registered WBR mode controls. Shift enables and the WBR clock enable are
// produced combinationally from those controls and the live strobes.
module wir_sequencer #(
  parameter int WIR_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic WRCK,
  input  logic RESET,
  input  logic SelectWIR,
  input  logic CaptureWR,
  input  logic ShiftWR,
  input  logic UpdateWR,
  input  logic WSI,
  input  logic WPSE,
  output logic wir_so,
  output logic wir_extest,
  output logic wir_wpp_bypass,
  output logic wir_wbr_concat,
  output logic wir_wpc,
  output logic hold_inputs,
  output logic hold_outputs,
  output logic wse_inputs,
  output logic wse_outputs,
  output logic wbr_clk_en,
  output logic wir_len_err
);

  localparam logic [2:0] WS_BYPASS = 3'd0;
  localparam logic [2:0] WS_EXTEST = 3'd1;
  localparam logic [2:0] WS_INTEST = 3'd2;
  localparam logic [2:0] WP_EXTEST = 3'd3;
  localparam logic [2:0] WP_INTEST = 3'd4;
  localparam logic [2:0] WP_BYPASS = 3'd5;

  logic [WIR_LEN-1:0] shift_reg;
  logic [WIR_LEN-1:0] instr;
  logic [CNT_W-1:0]   cnt;
  logic               len_err;
  logic [2:0]         op;
  logic               multi_strobe;
  logic               wse;

  // Registered mode controls, one cycle behind the active instruction
  logic extest_q, concat_q, wpc_q, wpp_bypass_q, hold_q;

  assign multi_strobe = (CaptureWR & ShiftWR) | (CaptureWR & UpdateWR) | (ShiftWR & UpdateWR);

  // Qualify the opcode: any set upper bit or an unassigned code means WS_BYPASS
  always_comb begin
    op = WS_BYPASS;
    if (((instr >> 3) == '0) && (instr[2:0] <= WP_BYPASS)) op = instr[2:0];
  end

  // WIR shift/update path, shift counter and sticky length/overlap error
  always_ff @(posedge WRCK or posedge RESET) begin
    if (RESET) begin
      shift_reg <= '0;
      instr     <= '0;
      cnt       <= '0;
      len_err   <= 1'b0;
    end else begin
      if (multi_strobe) len_err <= 1'b1;
      if (SelectWIR) begin
        if (CaptureWR) begin
          shift_reg <= {instr[WIR_LEN-1:2], 2'b01};
          cnt       <= '0;
        end else if (ShiftWR) begin
          shift_reg <= {WSI, shift_reg[WIR_LEN-1:1]};
          if (cnt != '1) cnt <= cnt + CNT_W'(1);
        end else if (UpdateWR) begin
          instr <= shift_reg;
          // A well-formed load is exactly WIR_LEN shifts since the last capture
          if (cnt != CNT_W'(WIR_LEN)) len_err <= 1'b1;
        end
      end
    end
  end

  // Decode the active instruction into the WBR mode controls
  always_ff @(posedge WRCK or posedge RESET) begin
    if (RESET) begin
      extest_q     <= 1'b0;
      concat_q     <= 1'b0;
      wpc_q        <= 1'b0;
      wpp_bypass_q <= 1'b0;
      hold_q       <= 1'b0;
    end else begin
      extest_q     <= (op == WS_EXTEST) || (op == WP_EXTEST);
      concat_q     <= (op == WS_EXTEST) || (op == WS_INTEST);
      wpc_q        <= (op == WP_EXTEST) || (op == WP_INTEST) || (op == WP_BYPASS);
      wpp_bypass_q <= (op == WP_BYPASS);
      hold_q       <= (op == WS_EXTEST) || (op == WS_INTEST) ||
                      (op == WP_EXTEST) || (op == WP_INTEST);
    end
  end

  // WBR shift enable: serial modes follow ShiftWR, parallel test modes follow WPSE
  always_comb begin
    wse = 1'b0;
    if (!SelectWIR) begin
      if (concat_q)             wse = ShiftWR;
      else if (hold_q && wpc_q) wse = WPSE;
    end
  end

  assign wse_inputs     = wse;
  assign wse_outputs    = wse;
  // hold_q is exactly "not a bypass instruction"
  assign wbr_clk_en     = !SelectWIR && hold_q &&
                          (CaptureWR || ShiftWR || UpdateWR || (wpc_q && WPSE));
  assign wir_so         = shift_reg[0];
  assign wir_extest     = extest_q;
  assign wir_wbr_concat = concat_q;
  assign wir_wpc        = wpc_q;
  assign wir_wpp_bypass = wpp_bypass_q;
  assign hold_inputs    = hold_q;
  assign hold_outputs   = hold_q;
  assign wir_len_err    = len_err;

endmodule

// File: tb/tb_wir_sequencer.sv
// Bench for wir_sequencer: directed steps followed by randomized loads and
// WBR accesses, every output checked each cycle against an instruction-level model.
module tb_wir_sequencer;
  localparam int L    = 4;
  localparam int CMAX = 255;

  logic WRCK = 1'b0, RESET = 1'b0, SelectWIR = 1'b0, CaptureWR = 1'b0;
  logic ShiftWR = 1'b0, UpdateWR = 1'b0, WSI = 1'b0, WPSE = 1'b0;
  logic wir_so, wir_extest, wir_wpp_bypass, wir_wbr_concat, wir_wpc;
  logic hold_inputs, hold_outputs, wse_inputs, wse_outputs, wbr_clk_en, wir_len_err;

  int checks = 0;
  int errors = 0;

  // Model state: shift register value, active instruction, instruction seen by
  // the decoded outputs (one cycle later), shift count and sticky error.
  int m_sr, m_instr, m_dec, m_cnt;
  bit m_err;

  wir_sequencer #(.WIR_LEN(L), .CNT_W(8)) dut (
    .WRCK(WRCK), .RESET(RESET), .SelectWIR(SelectWIR), .CaptureWR(CaptureWR),
    .ShiftWR(ShiftWR), .UpdateWR(UpdateWR), .WSI(WSI), .WPSE(WPSE),
    .wir_so(wir_so), .wir_extest(wir_extest), .wir_wpp_bypass(wir_wpp_bypass),
    .wir_wbr_concat(wir_wbr_concat), .wir_wpc(wir_wpc), .hold_inputs(hold_inputs),
    .hold_outputs(hold_outputs), .wse_inputs(wse_inputs), .wse_outputs(wse_outputs),
    .wbr_clk_en(wbr_clk_en), .wir_len_err(wir_len_err)
  );

  always #5 WRCK = ~WRCK;

  // Instruction name from raw WIR value: upper bit set or code 6/7 -> WS_BYPASS
  function automatic int opcode(int v);
    if (v >= 8 || v > 5) return 0;
    return v;
  endfunction

  task automatic chk(string tag, logic act, logic exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, act, exp);
    end
  endtask

  task automatic check_outputs();
    int  op;
    bit  e_ext, e_cat, e_wpc, e_wpb, e_hold, e_wse, e_clk;
    op     = opcode(m_dec);
    e_ext  = (op == 1) || (op == 3);
    e_cat  = (op == 1) || (op == 2);
    e_wpc  = (op >= 3) && (op <= 5);
    e_wpb  = (op == 5);
    e_hold = (op >= 1) && (op <= 4);
    e_wse  = 1'b0;
    if (!SelectWIR) begin
      if (op == 1 || op == 2)      e_wse = ShiftWR;
      else if (op == 3 || op == 4) e_wse = WPSE;
    end
    e_clk = !SelectWIR && e_hold && (CaptureWR || ShiftWR || UpdateWR || (e_wpc && WPSE));
    chk("wir_so",         wir_so,         1'(m_sr & 1));
    chk("wir_extest",     wir_extest,     e_ext);
    chk("wir_wbr_concat", wir_wbr_concat, e_cat);
    chk("wir_wpc",        wir_wpc,        e_wpc);
    chk("wir_wpp_bypass", wir_wpp_bypass, e_wpb);
    chk("hold_inputs",    hold_inputs,    e_hold);
    chk("hold_outputs",   hold_outputs,   e_hold);
    chk("wse_inputs",     wse_inputs,     e_wse);
    chk("wse_outputs",    wse_outputs,    e_wse);
    chk("wbr_clk_en",     wbr_clk_en,     e_clk);
    chk("wir_len_err",    wir_len_err,    m_err);
  endtask

  // One clock: drive at negedge, check while clock is low, advance model at posedge
  task automatic cycle(bit sel, bit c, bit s, bit u, bit wsi, bit wpse);
    int old_instr;
    SelectWIR = sel; CaptureWR = c; ShiftWR = s; UpdateWR = u; WSI = wsi; WPSE = wpse;
    #1;
    check_outputs();
    @(posedge WRCK);
    old_instr = m_instr;
    if (int'(c) + int'(s) + int'(u) >= 2) m_err = 1'b1;
    if (sel) begin
      if (c) begin
        m_sr  = (m_instr & ((1 << L) - 4)) | 1;
        m_cnt = 0;
      end else if (s) begin
        m_sr  = (m_sr >> 1) | (int'(wsi) << (L - 1));
        m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      end else if (u) begin
        m_instr = m_sr;
        if (m_cnt != L) m_err = 1'b1;
      end
    end
    m_dec = old_instr;
    @(negedge WRCK);
  endtask

  // Asynchronous reset pulse while the clock is low; outputs must clear at once
  task automatic do_reset();
    SelectWIR = 0; CaptureWR = 0; ShiftWR = 0; UpdateWR = 0; WSI = 0; WPSE = 0;
    RESET = 1'b1;
    m_sr = 0; m_instr = 0; m_dec = 0; m_cnt = 0; m_err = 1'b0;
    #1;
    check_outputs();
    #1 RESET = 1'b0;
  endtask

  // Capture, nshifts shifts of val (LSB first), update, then two idle cycles
  task automatic load(int val, int nshifts);
    cycle(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < nshifts; i++) cycle(1, 0, 1, 0, 1'((val >> i) & 1), 0);
    cycle(1, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int v, k;
    @(negedge WRCK);

    // Reset state, then capture of WS_BYPASS gives 0001 -> wir_so 1,0,0,0
    do_reset();
    cycle(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);

    // WS_EXTEST: decode appears one cycle after the update edge; WBR shift via ShiftWR
    load(1, 4);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1'(i % 2), 0, 0, 1'(i % 3 == 0));

    // WP_BYPASS with WPSE high: no shift enables, no WBR clock
    load(5, 4);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1'(i % 2), 0, 0, 1);

    // WP_EXTEST: shift enables follow WPSE, ShiftWR ignored
    load(3, 4);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1'(i % 3 == 0), 0, 0, 1'(i % 2));
    cycle(1, 0, 0, 0, 0, 1);

    // Short shift sets the sticky error; opcode 7 and an upper-bit opcode decode as bypass
    load(2, 3);
    load(7, 4);
    cycle(0, 0, 1, 0, 0, 1);
    load(9, 4);
    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 1);

    // Strobe overlap on an otherwise clean load
    do_reset();
    load(4, 4);
    cycle(1, 1, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);

    // Reset mid-load of WS_INTEST, then update without capture
    load(1, 4);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 1, 0);
    do_reset();
    cycle(1, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);

    // Counter saturation: long shift run then update still flags the length
    do_reset();
    cycle(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) cycle(1, 0, 1, 0, 1'($urandom_range(0, 1)), 0);
    cycle(1, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);

    // Random legal loads followed by single-strobe WBR accesses
    do_reset();
    for (int n = 0; n < 40; n++) begin
      v = int'($urandom_range(0, 15));
      load(v, 4);
      for (int j = 0; j < 6; j++) begin
        k = int'($urandom_range(0, 3));
        cycle(0, k == 1, k == 2, k == 3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    // Unconstrained random traffic
    for (int n = 0; n < 200; n++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
